msg_column_scanner: RTL and testbench
=====================================

# msg_column_scanner

Sequential successor to the combinational per-character column generator. It walks a message of up to MAX_LEN character codes and emits one ROW_W-bit glyph column per accepted handshake. Blank separator columns are inserted between characters, and single-shot and looping modes are supported. It sits between the message store, which it reads through an address/code port, and the column-multiplexed LED matrix driver, which consumes columns via valid/ready.

## Interface
- ROW_W, 7: LEDs per column (bits of col_data)
- COLS_PER_CHAR, 5: glyph columns per character
- GAP_COLS, 1: blank columns after each character (0 allowed)
- MAX_LEN, 16: maximum message length; ADDR_W = clog2(MAX_LEN), LEN_W = clog2(MAX_LEN+1)
- CODE_W, 4: character code width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; honoured only in IDLE
- stop  in  1  abort; highest priority after reset
- loop_en  in  1  sampled with start; 1 = repeat message forever
- msg_len  in  LEN_W  sampled with start; values > MAX_LEN are clamped to MAX_LEN
- char_addr  out  ADDR_W  index of the character being fetched
- char_code  in  CODE_W  code at char_addr; combinational read, valid in the same cycle
- col_data  out  ROW_W  column pattern; bit 0 = top row
- col_valid  out  1  col_data valid
- col_ready  in  1  downstream accepts column
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a single-shot message completes

## Operation
- States: IDLE, FETCH, EMIT, GAP.
- IDLE + start:
  - latch len_q = min(msg_len, MAX_LEN) and loop_q = loop_en; char_idx = 0.
  - Go to FETCH, or, if len_q == 0, stay in IDLE and pulse done next cycle.
- FETCH: char_addr = char_idx. Capture char_code into code_q, set col_idx = 0, go to EMIT.
- EMIT:
  - col_valid = 1, col_data = glyph(code_q, col_idx).
  - On col_valid & col_ready: if col_idx == COLS_PER_CHAR-1, go to GAP (or to end-of-char if GAP_COLS == 0); otherwise increment col_idx.
- GAP:
  - col_valid = 1, col_data = 0, gap_idx counts 0..GAP_COLS-1.
  - The last accepted gap column triggers end-of-char.
- End-of-char:
  - If char_idx < len_q-1: increment char_idx, go to FETCH.
  - Else if loop_q: char_idx = 0, go to FETCH.
  - Else: pulse done, go to IDLE.
- Glyph table covers codes 0..10 = A,C,D,E,I,J,M,O,P,R,T. Codes 11..2^CODE_W-1 render all-zero columns. Example: I = 41,7F columns 41,41,7F,41,41 (hex).
- stop in any state: next cycle IDLE, col_valid = 0, no done pulse. Any in-flight column is dropped.
- start while busy: ignored. start and stop in the same IDLE cycle: stop wins and the block stays IDLE.
- reset, including mid-message: IDLE, char_idx = col_idx = gap_idx = 0, code_q = 0.
- Reset values: col_valid = 0, col_data = 0, busy = 0, done = 0, char_addr = 0.

## Timing
- start at cycle N: FETCH at N+1; first col_valid at N+2.
- Each character adds one FETCH cycle with col_valid = 0 (one-cycle bubble per character).
- With col_ready held at 1, one character takes 1 + COLS_PER_CHAR + GAP_COLS cycles.
- col_data and col_valid are registered state decodes. They hold stable while col_valid & !col_ready; col_valid never drops without a handshake except on stop or reset.
- done is asserted in the cycle after the final handshake, coincident with the return to IDLE. busy falls in the same cycle.
- Counters never wrap silently. char_idx only advances under the end-of-char rule above.

## Structure
- Shared package holds:
  - character code constants (CH_A..CH_T, CH_BLANK = all-ones)
  - state enum
  - the default ROW_W/COLS_PER_CHAR values
- Sub-module glyph_rom: combinational (code, col_idx) → ROW_W column. It absorbs the existing per-character tables and their multiplexer.
- The scanner holds only the FSM, counters and handshake registers.

## Test plan
- Message "I" (code 4), len 1, loop 0, col_ready = 1: start → columns 41,41,7F,41,41,00 on consecutive cycles from N+2. done at the cycle after the last 00; busy low after.
- Backpressure: same message with col_ready toggled 1,0,0,1,…: every column is delivered exactly once in order, and col_data stays stable across every stalled cycle.
- GAP_COLS = 0, two characters "II", loop 1: exactly 10 data columns per pass with one invalid FETCH cycle between characters. char_addr sequence is 0,1,0,1…; done is never asserted.
- msg_len = 0 → done pulse one cycle after start, col_valid never asserted. msg_len = MAX_LEN+3 → exactly MAX_LEN characters fetched.
- stop during third column of the second character → col_valid = 0 next cycle, busy = 0, no done. A new start replays the message from char_addr = 0.
- Synchronous reset asserted mid-GAP → next cycle all outputs 0, state IDLE. Code 13 renders five 00 columns.

Source files
------------

// File: rtl/msg_column_scanner_pkg.sv
// Shared definitions for the message column scanner: character codes,
// scanner state encoding and default geometry of the glyph font.
package msg_column_scanner_pkg;

    localparam int DEF_ROW_W         = 7;
    localparam int DEF_COLS_PER_CHAR = 5;
    localparam int DEF_CODE_W        = 4;

    // Character codes understood by the glyph ROM; anything above CH_T is blank.
    localparam logic [DEF_CODE_W-1:0] CH_A     = 4'd0;
    localparam logic [DEF_CODE_W-1:0] CH_C     = 4'd1;
    localparam logic [DEF_CODE_W-1:0] CH_D     = 4'd2;
    localparam logic [DEF_CODE_W-1:0] CH_E     = 4'd3;
    localparam logic [DEF_CODE_W-1:0] CH_I     = 4'd4;
    localparam logic [DEF_CODE_W-1:0] CH_J     = 4'd5;
    localparam logic [DEF_CODE_W-1:0] CH_M     = 4'd6;
    localparam logic [DEF_CODE_W-1:0] CH_O     = 4'd7;
    localparam logic [DEF_CODE_W-1:0] CH_P     = 4'd8;
    localparam logic [DEF_CODE_W-1:0] CH_R     = 4'd9;
    localparam logic [DEF_CODE_W-1:0] CH_T     = 4'd10;
    localparam logic [DEF_CODE_W-1:0] CH_BLANK = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2,
        ST_GAP   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/msg_column_scanner_glyph_rom.sv
// Combinational 5x7 glyph font: (character code, column index) -> column
// pattern, bit 0 = top row. Unknown codes and columns past the glyph are blank.
module msg_column_scanner_glyph_rom
    import msg_column_scanner_pkg::*;
#(
    parameter int ROW_W  = DEF_ROW_W,
    parameter int CODE_W = DEF_CODE_W,
    parameter int CIDX_W = 3
) (
    input  logic [CODE_W-1:0] i_code,
    input  logic [CIDX_W-1:0] i_col,
    output logic [ROW_W-1:0]  o_col
);

    localparam int GLYPH_COLS = 5;

    // Index 0 is the leftmost column, so each table row reads left to right.
    logic [0:GLYPH_COLS-1][6:0] w_glyph;
    logic [6:0]                 w_sel;

    // Per-character column table.
    always_comb begin
        w_glyph = '0;
        case (i_code)
            CODE_W'(CH_A): w_glyph = {7'h7C, 7'h12, 7'h11, 7'h12, 7'h7C};
            CODE_W'(CH_C): w_glyph = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
            CODE_W'(CH_D): w_glyph = {7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C};
            CODE_W'(CH_E): w_glyph = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
            CODE_W'(CH_I): w_glyph = {7'h41, 7'h41, 7'h7F, 7'h41, 7'h41};
            CODE_W'(CH_J): w_glyph = {7'h20, 7'h40, 7'h41, 7'h3F, 7'h01};
            CODE_W'(CH_M): w_glyph = {7'h7F, 7'h02, 7'h1C, 7'h02, 7'h7F};
            CODE_W'(CH_O): w_glyph = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E};
            CODE_W'(CH_P): w_glyph = {7'h7F, 7'h09, 7'h09, 7'h09, 7'h06};
            CODE_W'(CH_R): w_glyph = {7'h7F, 7'h09, 7'h19, 7'h29, 7'h46};
            CODE_W'(CH_T): w_glyph = {7'h01, 7'h01, 7'h7F, 7'h01, 7'h01};
            default:       w_glyph = '0;
        endcase
    end

    // Column multiplexer; out-of-range column indices render blank.
    always_comb begin
        w_sel = 7'h00;
        if (int'(i_col) < GLYPH_COLS) begin
            w_sel = w_glyph[i_col];
        end
    end

    assign o_col = ROW_W'(w_sel);

endmodule

// File: rtl/msg_column_scanner.sv
// Message column scanner: walks a stored message one character at a time and
// streams glyph columns (plus blank separators) to the LED matrix driver.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; outputs quiet
//   FETCH | char_addr presented, char_code captured; one bubble cycle
//   EMIT  | presenting glyph column col_idx of the captured character
//   GAP   | presenting blank separator column gap_idx
module msg_column_scanner
    import msg_column_scanner_pkg::*;
#(
    parameter  int ROW_W         = DEF_ROW_W,
    parameter  int COLS_PER_CHAR = DEF_COLS_PER_CHAR,
    parameter  int GAP_COLS      = 1,
    parameter  int MAX_LEN       = 16,
    parameter  int CODE_W        = DEF_CODE_W,
    localparam int ADDR_W        = $clog2(MAX_LEN),
    localparam int LEN_W         = $clog2(MAX_LEN + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop_en,
    input  logic [LEN_W-1:0]  i_msg_len,
    output logic [ADDR_W-1:0] o_char_addr,
    input  logic [CODE_W-1:0] i_char_code,
    output logic [ROW_W-1:0]  o_col_data,
    output logic              o_col_valid,
    input  logic              i_col_ready,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CIDX_W = (COLS_PER_CHAR > 1) ? $clog2(COLS_PER_CHAR) : 1;
    localparam int GIDX_W = (GAP_COLS > 1) ? $clog2(GAP_COLS) : 1;

    localparam logic [CIDX_W-1:0] COL_LAST = CIDX_W'(COLS_PER_CHAR - 1);
    localparam logic [GIDX_W-1:0] GAP_LAST = GIDX_W'((GAP_COLS > 0) ? GAP_COLS - 1 : 0);
    localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);

    scan_state_t       r_state;
    logic [LEN_W-1:0]  r_len;
    logic              r_loop;
    logic [ADDR_W-1:0] r_char_idx;
    logic [CODE_W-1:0] r_code;
    logic [CIDX_W-1:0] r_col_idx;
    logic [GIDX_W-1:0] r_gap_idx;
    logic              r_done;

    scan_state_t       w_state_nxt;
    logic [LEN_W-1:0]  w_len_nxt;
    logic              w_loop_nxt;
    logic [ADDR_W-1:0] w_char_idx_nxt;
    logic [CODE_W-1:0] w_code_nxt;
    logic [CIDX_W-1:0] w_col_idx_nxt;
    logic [GIDX_W-1:0] w_gap_idx_nxt;
    logic              w_done_nxt;
    logic              w_eoc;
    logic              w_more_chars;
    logic [LEN_W-1:0]  w_len_clamp;
    logic [ROW_W-1:0]  w_glyph_col;

    msg_column_scanner_glyph_rom #(
        .ROW_W  (ROW_W),
        .CODE_W (CODE_W),
        .CIDX_W (CIDX_W)
    ) u_glyph_rom (
        .i_code (r_code),
        .i_col  (r_col_idx),
        .o_col  (w_glyph_col)
    );

    assign w_len_clamp  = (i_msg_len > LEN_MAX) ? LEN_MAX : i_msg_len;
    // Compare in LEN_W so char_idx + 1 cannot overflow at MAX_LEN-1.
    assign w_more_chars = ((LEN_W'(r_char_idx) + LEN_W'(1)) < r_len);

    // Next-state and counter update; stop overrides everything but reset.
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_loop_nxt     = r_loop;
        w_char_idx_nxt = r_char_idx;
        w_code_nxt     = r_code;
        w_col_idx_nxt  = r_col_idx;
        w_gap_idx_nxt  = r_gap_idx;
        w_done_nxt     = 1'b0;
        w_eoc          = 1'b0;

        if (i_stop) begin
            w_state_nxt    = ST_IDLE;
            w_char_idx_nxt = '0;
            w_col_idx_nxt  = '0;
            w_gap_idx_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_len_nxt      = w_len_clamp;
                        w_loop_nxt     = i_loop_en;
                        w_char_idx_nxt = '0;
                        if (w_len_clamp == '0) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    w_code_nxt    = i_char_code;
                    w_col_idx_nxt = '0;
                    w_gap_idx_nxt = '0;
                    w_state_nxt   = ST_EMIT;
                end
                ST_EMIT: begin
                    if (i_col_ready) begin
                        if (r_col_idx == COL_LAST) begin
                            if (GAP_COLS == 0) begin
                                w_eoc = 1'b1;
                            end else begin
                                w_gap_idx_nxt = '0;
                                w_state_nxt   = ST_GAP;
                            end
                        end else begin
                            w_col_idx_nxt = r_col_idx + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (i_col_ready) begin
                        if (r_gap_idx == GAP_LAST) begin
                            w_eoc = 1'b1;
                        end else begin
                            w_gap_idx_nxt = r_gap_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            if (w_eoc) begin
                if (w_more_chars) begin
                    w_char_idx_nxt = r_char_idx + 1'b1;
                    w_state_nxt    = ST_FETCH;
                end else if (r_loop) begin
                    w_char_idx_nxt = '0;
                    w_state_nxt    = ST_FETCH;
                end else begin
                    w_char_idx_nxt = '0;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end
        end
    end

    // State, counters and done pulse register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_loop     <= 1'b0;
            r_char_idx <= '0;
            r_code     <= '0;
            r_col_idx  <= '0;
            r_gap_idx  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_len      <= w_len_nxt;
            r_loop     <= w_loop_nxt;
            r_char_idx <= w_char_idx_nxt;
            r_code     <= w_code_nxt;
            r_col_idx  <= w_col_idx_nxt;
            r_gap_idx  <= w_gap_idx_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Outputs decode registered state only, so they stay stable under stall.
    always_comb begin
        o_col_valid = (r_state == ST_EMIT) || (r_state == ST_GAP);
        o_col_data  = (r_state == ST_EMIT) ? w_glyph_col : '0;
        o_busy      = (r_state != ST_IDLE);
        o_done      = r_done;
        o_char_addr = r_char_idx;
    end

endmodule

// File: tb/tb_msg_column_scanner.sv
// Scoreboard bench for msg_column_scanner: stimulus pushes expected columns,
// negedge monitors pop and compare on every accepted column.
module tb_msg_column_scanner;

    logic       clk;
    logic       reset;

    logic       start_a, stop_a, loop_a, ready_a;
    logic [4:0] len_a;
    logic [3:0] addr_a, code_a;
    logic [6:0] data_a;
    logic       valid_a, busy_a, done_a;

    logic       start_b, stop_b, loop_b, ready_b;
    logic [4:0] len_b;
    logic [3:0] addr_b, code_b;
    logic [6:0] data_b;
    logic       valid_b, busy_b, done_b;

    logic [3:0] mem [16];

    logic [6:0] exp_a [$];
    logic [6:0] exp_b [$];

    int n_cmp = 0;
    int n_err = 0;

    logic       stab_en = 1'b0;
    logic       prev_stall_a = 1'b0;
    logic [6:0] prev_data_a = '0;

    assign code_a = mem[addr_a];
    assign code_b = mem[addr_b];

    msg_column_scanner #(.GAP_COLS(1)) u_dut_a (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start_a),
        .i_stop      (stop_a),
        .i_loop_en   (loop_a),
        .i_msg_len   (len_a),
        .o_char_addr (addr_a),
        .i_char_code (code_a),
        .o_col_data  (data_a),
        .o_col_valid (valid_a),
        .i_col_ready (ready_a),
        .o_busy      (busy_a),
        .o_done      (done_a)
    );

    msg_column_scanner #(.GAP_COLS(0)) u_dut_b (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start_b),
        .i_stop      (stop_b),
        .i_loop_en   (loop_b),
        .i_msg_len   (len_b),
        .o_char_addr (addr_b),
        .i_char_code (code_b),
        .o_col_data  (data_b),
        .o_col_valid (valid_b),
        .i_col_ready (ready_b),
        .o_busy      (busy_b),
        .o_done      (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-entered font, bit 0 = top row.
    function automatic logic [6:0] gl(input int code, input int col);
        logic [6:0] t [5];
        case (code)
            0:  t = '{7'h7C, 7'h12, 7'h11, 7'h12, 7'h7C};
            1:  t = '{7'h3E, 7'h41, 7'h41, 7'h41, 7'h22};
            2:  t = '{7'h7F, 7'h41, 7'h41, 7'h22, 7'h1C};
            3:  t = '{7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
            4:  t = '{7'h41, 7'h41, 7'h7F, 7'h41, 7'h41};
            5:  t = '{7'h20, 7'h40, 7'h41, 7'h3F, 7'h01};
            6:  t = '{7'h7F, 7'h02, 7'h1C, 7'h02, 7'h7F};
            7:  t = '{7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E};
            8:  t = '{7'h7F, 7'h09, 7'h09, 7'h09, 7'h06};
            9:  t = '{7'h7F, 7'h09, 7'h19, 7'h29, 7'h46};
            10: t = '{7'h01, 7'h01, 7'h7F, 7'h01, 7'h01};
            default: t = '{default: 7'h00};
        endcase
        return t[col];
    endfunction

    task automatic push_char_a(input int code);
        for (int c = 0; c < 5; c++) exp_a.push_back(gl(code, c));
        exp_a.push_back(7'h00);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor for the GAP_COLS=1 instance, plus stall stability tracking.
    always @(negedge clk) begin
        if (!reset) begin
            if (stab_en && prev_stall_a) begin
                check("a_stall_valid", valid_a, 1);
                check("a_stall_data", data_a, prev_data_a);
            end
            if (valid_a && ready_a) begin
                if (exp_a.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL a_unexpected_col: got 0x%0h with empty queue at %0t", data_a, $time);
                end else begin
                    check("a_col", data_a, exp_a.pop_front());
                end
            end
        end
        prev_stall_a = valid_a && !ready_a;
        prev_data_a  = data_a;
    end

    // Monitor for the GAP_COLS=0 instance.
    always @(negedge clk) begin
        if (!reset && valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_unexpected_col: got 0x%0h with empty queue at %0t", data_b, $time);
            end else begin
                check("b_col", data_b, exp_b.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  fcnt;
        bit  seen;

        reset = 1'b1;
        start_a = 0; stop_a = 0; loop_a = 0; len_a = '0; ready_a = 1;
        start_b = 0; stop_b = 0; loop_b = 0; len_b = '0; ready_b = 1;
        for (int i = 0; i < 16; i++) mem[i] = 4'd0;
        repeat (3) tick();

        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_b_valid", valid_b, 0);
        reset = 1'b0;
        tick();

        // Single "I", ready held high: exact cycle timing.
        mem[0] = 4'd4;
        push_char_a(4);
        len_a = 5'd1; loop_a = 0;
        start_a = 1; tick(); start_a = 0;
        check("t1_fetch_valid", valid_a, 0);
        check("t1_fetch_busy", busy_a, 1);
        check("t1_fetch_addr", addr_a, 0);
        tick();
        check("t1_first_valid", valid_a, 1);
        check("t1_first_col", data_a, 7'h41);
        repeat (5) tick();
        check("t1_gap_valid", valid_a, 1);
        check("t1_gap_col", data_a, 7'h00);
        tick();
        check("t1_done", done_a, 1);
        check("t1_busy_low", busy_a, 0);
        check("t1_valid_low", valid_a, 0);
        tick();
        check("t1_done_pulse", done_a, 0);
        check("t1_queue_empty", exp_a.size(), 0);

        // Backpressure with ready pattern 1,0,0,1.
        push_char_a(4);
        stab_en = 1;
        start_a = 1; tick(); start_a = 0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            ready_a = ((i % 4) == 0) || ((i % 4) == 3);
            tick();
            if (done_a) begin
                seen = 1;
                break;
            end
        end
        stab_en = 0;
        ready_a = 1;
        check("bp_done_seen", seen, 1);
        check("bp_queue_empty", exp_a.size(), 0);

        // Zero-length message.
        len_a = 5'd0;
        start_a = 1; tick(); start_a = 0;
        check("len0_done", done_a, 1);
        check("len0_valid", valid_a, 0);
        check("len0_busy", busy_a, 0);
        tick();
        check("len0_done_pulse", done_a, 0);

        // Over-length request clamps to 16 characters; codes 11..15 are blank.
        for (int i = 0; i < 16; i++) begin
            mem[i] = 4'(i);
            push_char_a(i);
        end
        len_a = 5'd19;
        start_a = 1; tick(); start_a = 0;
        fcnt = 0; seen = 0;
        for (int cyc = 0; cyc < 250; cyc++) begin
            if (done_a) begin
                seen = 1;
                break;
            end
            if (busy_a && !valid_a) begin
                check("clamp_fetch_addr", addr_a, fcnt);
                fcnt++;
            end
            tick();
        end
        check("clamp_done_seen", seen, 1);
        check("clamp_fetch_count", fcnt, 16);
        check("clamp_queue_empty", exp_a.size(), 0);

        // Stop during the third column of the second character ("ACD").
        len_a = 5'd3;
        push_char_a(0);
        exp_a.push_back(gl(1, 0));
        exp_a.push_back(gl(1, 1));
        start_a = 1; tick(); start_a = 0;
        repeat (10) tick();
        ready_a = 0;
        check("stop_addr", addr_a, 1);
        check("stop_col2", data_a, gl(1, 2));
        stop_a = 1; tick(); stop_a = 0;
        ready_a = 1;
        check("stop_valid", valid_a, 0);
        check("stop_busy", busy_a, 0);
        check("stop_done", done_a, 0);
        tick();
        check("stop_no_done", done_a, 0);
        check("stop_queue_empty", exp_a.size(), 0);

        push_char_a(0);
        push_char_a(1);
        push_char_a(2);
        start_a = 1; tick(); start_a = 0;
        check("replay_addr", addr_a, 0);
        seen = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            tick();
            if (done_a) begin
                seen = 1;
                break;
            end
        end
        check("replay_done_seen", seen, 1);
        check("replay_queue_empty", exp_a.size(), 0);

        // Synchronous reset while a gap column is presented.
        mem[0] = 4'd4;
        for (int c = 0; c < 5; c++) exp_a.push_back(gl(4, c));
        len_a = 5'd1;
        start_a = 1; tick(); start_a = 0;
        repeat (6) tick();
        check("rst_gap_valid", valid_a, 1);
        check("rst_gap_data", data_a, 0);
        ready_a = 0;
        reset = 1; tick();
        check("midrst_valid", valid_a, 0);
        check("midrst_data", data_a, 0);
        check("midrst_busy", busy_a, 0);
        check("midrst_done", done_a, 0);
        check("midrst_addr", addr_a, 0);
        reset = 0; ready_a = 1;
        tick();
        check("midrst_after_done", done_a, 0);
        check("midrst_after_valid", valid_a, 0);
        check("midrst_queue_empty", exp_a.size(), 0);

        // GAP_COLS=0, "II" looping: two passes, one bubble per character.
        mem[0] = 4'd4;
        mem[1] = 4'd4;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 5; c++) exp_b.push_back(gl(4, c));
        len_b = 5'd2; loop_b = 1;
        start_b = 1; tick(); start_b = 0;
        for (int i = 0; i < 24; i++) begin
            if ((i % 6) == 0) begin
                check("b_fetch_valid", valid_b, 0);
                check("b_fetch_addr", addr_b, (i / 6) % 2);
            end else begin
                check("b_data_valid", valid_b, 1);
            end
            check("b_no_done", done_b, 0);
            tick();
        end
        check("b_wrap_valid", valid_b, 0);
        check("b_wrap_busy", busy_b, 1);
        check("b_wrap_addr", addr_b, 0);
        stop_b = 1; tick(); stop_b = 0;
        check("b_stop_busy", busy_b, 0);
        check("b_stop_done", done_b, 0);
        check("b_queue_empty", exp_b.size(), 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
